// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and line idle level.
// Used by both the receiver and the transmitter; contains no logic.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is a parameter.
// Latency 2 clk; no flow control.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit and pulses valid (or frame_err on a low stop bit).
// Result appears 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the pin edge; no backpressure.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(UART_DATA_BITS - 1);

    logic                      rx_s;
    uart_state_t               state, state_n;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic [IDX_W-1:0]          bit_idx, bit_idx_n;
    logic [UART_DATA_BITS-1:0] shreg, shreg_n;
    logic [UART_DATA_BITS-1:0] data_n;
    logic                      valid_n;
    logic                      frame_err_n;

    // Both stages reset to the idle level so leaving reset never looks like a start bit.
    uart_sync2 #(
        .RESET_VAL(UART_IDLE_LEVEL)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        data_n      = data;
        valid_n     = 1'b0;
        frame_err_n = 1'b0;

        unique case (state)
            IDLE: begin
                if (rx_s == 1'b0) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end

            START: begin
                if (cnt == CNT_HALF_LAST) begin
                    cnt_n = '0;
                    // A line that is high again at the start-bit centre was only a glitch.
                    if (rx_s == 1'b0) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_n            = '0;
                    shreg_n[bit_idx] = rx_s;
                    if (bit_idx == IDX_LAST) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt == CNT_BIT_LAST) begin
                    cnt_n = '0;
                    // Returning to IDLE mid-stop-bit lets a back-to-back start edge be caught.
                    if (rx_s == 1'b1) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = BREAK;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            BREAK: begin
                if (rx_s == 1'b1) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the 8N1 UART link. It deserialises frames from the asynchronous `rx` line: one start bit (0), eight data bits LSB first, and one stop bit (1). Each complete byte is presented as a one-cycle `valid` pulse. It is the receive-side counterpart of the existing UART transmitter and sits between the board RX pin and the Nios-facing register interface. Bit timing comes from a fixed clocks-per-bit count, and each bit is sampled at its nominal centre.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Must be ≥ 4.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (integer divide, floor): offset from the start edge to the start-bit centre. Derived; do not override.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `rx`, input, 1: asynchronous serial line. Idles high.
- `data`, output, 8: last received byte. Holds until the next good frame.
- `valid`, output, 1: one-cycle pulse; `data` is new this cycle.
- `frame_err`, output, 1: one-cycle pulse; the stop bit was sampled low.
- `busy`, output, 1: high while a frame is in progress (any state except IDLE).

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1 so reset cannot create a false start.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - `rx_s`==0 → START, clear `cnt`.
  - Otherwise stay.
  - IDLE is entered only after the line was seen high, so level detection is sufficient.
- START:
  - Count to `HALF_BIT`-1, then sample `rx_s`.
  - 0 → DATA, clear `cnt` and `bit_idx`.
  - 1 → glitch; return to IDLE with no output.
- DATA:
  - Count to `CLKS_PER_BIT`-1, then shift `rx_s` into `shreg` bit `bit_idx` (LSB first) and clear `cnt`.
  - After bit 7, go to STOP.
- STOP:
  - Count to `CLKS_PER_BIT`-1, then sample `rx_s`.
  - 1 → `data` ← `shreg`, `valid`=1 next cycle, go to IDLE.
  - 0 → `frame_err`=1 next cycle, `data` unchanged, go to BREAK.
- BREAK: wait for `rx_s`==1, then go to IDLE. A held-low line (break) yields exactly one `frame_err`.
- `cnt` width is `$clog2(CLKS_PER_BIT)`. It never wraps; it is cleared on every sample.
- `bit_idx` is 3 bits. Bit 7 is the terminal index; it never wraps past 7.
- There is no backpressure. The consumer must capture `data` on `valid`. The next `valid` occurs at least 10·`CLKS_PER_BIT` cycles later.

## Timing
- Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, state=IDLE, `cnt`=0, `bit_idx`=0.
- Let t0 be the first cycle `rx_s`==0 in IDLE. The synchronizer adds 2 cycles from the pin.
  - The start sample is at t0+`HALF_BIT`.
  - Data bit i is sampled at t0+`HALF_BIT`+(i+1)·`CLKS_PER_BIT`.
  - The stop bit is sampled at t0+`HALF_BIT`+9·`CLKS_PER_BIT`.
  - `valid` or `frame_err` is high in the following cycle.
  - For `CLKS_PER_BIT`=16: stop is sampled at t0+152 and `valid` is high at t0+153.
- `busy` rises the cycle after t0 and falls in the same cycle that `valid` or `frame_err` is high. For a framing error, `busy` stays high through BREAK.
- Back-to-back frames: a new start bit immediately after the stop bit is accepted, because IDLE is reached mid-stop-bit.
- `rst` mid-frame: the frame is aborted and no `valid` or `frame_err` is produced. All outputs take their reset values in the next cycle.
- `valid` and `frame_err` are never high together.

## Structure
- The shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK);
  - `UART_DATA_BITS`=8;
  - the `UART_IDLE_LEVEL`=1 constant, shared with the transmitter.
- Sub-module `uart_sync2`: a 2-flop synchronizer with a reset-value parameter (here 1). It is reusable for other async inputs.
- Everything else (FSM, counters, shift register) lives in `uart_rx`.

## Test plan
- Reset with `rx`=1, then 20 idle bit-times → `data`=00, and `valid`, `frame_err` and `busy` never assert.
- Frame 0xA5 at `CLKS_PER_BIT`=16 → single `valid` pulse at pin-edge+155 cycles, `data`=A5.
- Frames 0x00, 0xFF, 0x3C sent back-to-back with no idle gap → three `valid` pulses 160 cycles apart, data 00, FF, 3C.
- 5-cycle low glitch on idle `rx` → no output; a following frame 0x81 is received correctly.
- Frame 0x55 with the stop bit low, then the line held low for 3 bit-times, then released → exactly one `frame_err`, `data` keeps its previous value, then a frame 0x12 is received.
- `rst` asserted during data bit 4 of frame 0x7E → no `valid`; `busy`=0 next cycle; a following frame 0x7E is received correctly.
- Repeat the 0xA5 case at `CLKS_PER_BIT`=5 (odd, `HALF_BIT`=2) and with ±3% transmitter bit-rate skew → correct data.
